// File: rtl/bus_gnrtr_n_rbtr_if.sv
// Driver-side bundle of the bus generator/arbiter: FIFO status and head packets in, pop/push strobes and delivered packets out.
interface bus_gnrtr_n_rbtr_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

  modport master (output pndng, D_pop, input pop, push, D_push);
  modport slave  (input pndng, D_pop, output pop, push, D_push);
endinterface

// File: rtl/bus_gnrtr_n_rbtr.sv
// Per-bus round-robin arbiter: pops one packet from the winning driver FIFO and delivers it by destination ID.
// Macro BUS_BROADCAST_EN enables delivery of the broadcast ID to every driver except the source.
module bus_gnrtr_n_rbtr #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  bus_gnrtr_n_rbtr_if.slave bus
);
  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH, GAP} state_t;

  state_t             st  [bits];
  logic [PW-1:0]      ptr [bits];
  logic [pckg_sz-1:0] pkt [bits];
`ifdef BUS_BROADCAST_EN
  logic [PW-1:0]      src [bits];
`endif
  logic [bits-1:0][drvrs-1:0]              pop_q;
  logic [bits-1:0][drvrs-1:0]              push_q;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] dpush_q;

  // First pending driver at or above the pointer, wrapping around.
  function automatic logic [PW-1:0] pick(input logic [drvrs-1:0] req, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < drvrs; k++) begin
      idx = (int'(p) + k) % drvrs;
      if (!found && req[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
    return PW'((int'(w) + 1) % drvrs);
  endfunction

  function automatic logic [drvrs-1:0] onehot(input logic [PW-1:0] w);
    logic [drvrs-1:0] v;
    for (int i = 0; i < drvrs; i++) v[i] = (int'(w) == i);
    return v;
  endfunction

`ifdef BUS_BROADCAST_EN
  function automatic logic hit(input logic [7:0] d, input logic [PW-1:0] s, input int i);
    if (d == broadcast) return (i != int'(s));
    return (int'(d) < drvrs) && (int'(d) == i);
  endfunction
`else
  // Broadcast ID is just another invalid destination here.
  function automatic logic hit(input logic [7:0] d, input int i);
    return (d != broadcast) && (int'(d) < drvrs) && (int'(d) == i);
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < bits; b++) begin
        st[b]  <= IDLE;
        ptr[b] <= '0;
        pkt[b] <= '0;
`ifdef BUS_BROADCAST_EN
        src[b] <= '0;
`endif
      end
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
    end else begin
      for (int b = 0; b < bits; b++) begin
        case (st[b])
          // Grant: latch winner's head packet and strobe its FIFO pop.
          IDLE: begin
            if (|bus.pndng[b]) begin
              pkt[b]   <= bus.D_pop[b][pick(bus.pndng[b], ptr[b])];
`ifdef BUS_BROADCAST_EN
              src[b]   <= pick(bus.pndng[b], ptr[b]);
`endif
              pop_q[b] <= onehot(pick(bus.pndng[b], ptr[b]));
              ptr[b]   <= nxt(pick(bus.pndng[b], ptr[b]));
              st[b]    <= POP;
            end
          end
          // Deliver: decode destination, packet goes out on every lane.
          POP: begin
            pop_q[b] <= '0;
            for (int i = 0; i < drvrs; i++) begin
`ifdef BUS_BROADCAST_EN
              push_q[b][i] <= hit(pkt[b][pckg_sz-1 -: 8], src[b], i);
`else
              push_q[b][i] <= hit(pkt[b][pckg_sz-1 -: 8], i);
`endif
              dpush_q[b][i] <= pkt[b];
            end
            st[b] <= PUSH;
          end
          PUSH: begin
            push_q[b] <= '0;
            st[b]     <= GAP;
          end
          // Idle cycle lets the FIFO's pndng reflect the pop before re-arbitrating.
          GAP:     st[b] <= IDLE;
          default: st[b] <= IDLE;
        endcase
      end
    end
  end

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = dpush_q;
endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Randomized and directed bench for bus_gnrtr_n_rbtr against a transaction-level arbitration model.
module tb_bus_gnrtr_n_rbtr;
  localparam int         BITS  = 1;
  localparam int         DRV   = 4;
  localparam int         PSZ   = 16;
  localparam logic [7:0] BCAST = 8'hFF;
`ifdef BUS_BROADCAST_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_gnrtr_n_rbtr_if #(.bits(BITS), .drvrs(DRV), .pckg_sz(PSZ)) bif ();

  bus_gnrtr_n_rbtr #(.bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .broadcast(BCAST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int          nchk = 0;
  int          nerr = 0;
  logic [15:0] fifo [DRV][$];
  int          ptr_m;
  int          cnt_m;
  logic [3:0]  prev_pnd;
  logic [15:0] prev_head [DRV];
  logic [3:0]  push_due;
  logic [15:0] push_data;
  logic [3:0]  obs_pop, obs_push;
  logic [63:0] obs_dpush;
  bit          rand_on;
  logic [3:0]  hp [12];
  logic [3:0]  hq [12];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Round-robin choice: first requester at or after p, wrapping.
  function automatic int rr(input logic [3:0] req, input int p);
    for (int k = 0; k < DRV; k++)
      if (req[(p + k) % DRV]) return (p + k) % DRV;
    return 0;
  endfunction

  function automatic logic [3:0] targets(input logic [15:0] p, input int s);
    int d;
    d = int'(p[15:8]);
    if (d < DRV) return 4'(1 << d);
    if (d == int'(BCAST)) return BC_EN ? (4'hF & ~4'(1 << s)) : 4'h0;
    return 4'h0;
  endfunction

  task automatic drive();
    for (int i = 0; i < DRV; i++) begin
      prev_pnd[i]  = (fifo[i].size() != 0);
      prev_head[i] = (fifo[i].size() != 0) ? fifo[i][0] : 16'h0;
      bif.pndng[0][i] = prev_pnd[i];
      bif.D_pop[0][i] = prev_head[i];
    end
  endtask

  task automatic load(input int d, input logic [15:0] p);
    fifo[d].push_back(p);
    drive();
  endtask

  task automatic model_reset();
    cnt_m     = 0;
    ptr_m     = 0;
    push_due  = '0;
    push_data = '0;
    for (int i = 0; i < DRV; i++) fifo[i].delete();
    drive();
  endtask

  function automatic logic [15:0] rpkt();
    int   sel;
    logic [7:0] d;
    sel = $urandom_range(0, 9);
    if (sel < 7)       d = 8'($urandom_range(0, 3));
    else if (sel == 7) d = BCAST;
    else if (sel == 8) d = 8'h09;
    else               d = 8'($urandom_range(0, 255));
    return {d, 8'($urandom)};
  endfunction

  task automatic step();
    int          w;
    int          d;
    logic [3:0]  exp_pop, exp_push;
    logic [15:0] exp_data;
    @(posedge clk);
    #1;
    obs_pop   = bif.pop[0];
    obs_push  = bif.push[0];
    obs_dpush = bif.D_push[0];
    exp_push  = push_due;
    exp_data  = push_data;
    push_due  = '0;
    exp_pop   = '0;
    if (cnt_m == 0 && prev_pnd != 4'h0) begin
      w         = rr(prev_pnd, ptr_m);
      exp_pop   = 4'(1 << w);
      push_due  = targets(prev_head[w], w);
      push_data = prev_head[w];
      ptr_m     = (w + 1) % DRV;
      cnt_m     = 3;
    end else if (cnt_m > 0) begin
      cnt_m--;
    end
    chk("pop", obs_pop, exp_pop);
    chk("push", obs_push, exp_push);
    for (int i = 0; i < DRV; i++)
      if (exp_push[i]) chk("dpush", obs_dpush[i*16 +: 16], exp_data);
    for (int i = 0; i < DRV; i++)
      if (obs_pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    if (rand_on && $urandom_range(0, 2) == 0) begin
      d = $urandom_range(0, DRV - 1);
      if (fifo[d].size() < 4) fifo[d].push_back(rpkt());
    end
    drive();
  endtask

  initial begin
    reset   = 1'b0;
    rand_on = 1'b0;
    model_reset();
    #12;
    chk("rst_pop", bif.pop, 0);
    chk("rst_push", bif.push, 0);
    chk("rst_dpush", bif.D_push, 0);
    @(posedge clk);
    #3 reset = 1'b1;

    // Three simultaneous requesters from pointer 0.
    load(0, 16'h0204); load(1, 16'h0202); load(2, 16'h0203);
    for (int k = 0; k < 12; k++) begin
      step();
      hp[k] = obs_pop;
      hq[k] = obs_push;
    end
    chk("rr_pop0", hp[0], 4'b0001);
    chk("rr_pop1", hp[4], 4'b0010);
    chk("rr_pop2", hp[8], 4'b0100);
    chk("rr_push0", hq[1], 4'b0100);
    chk("rr_push1", hq[5], 4'b0100);
    chk("rr_push2", hq[9], 4'b0100);

    // Single packet from driver 1 to driver 2.
    load(1, 16'h0202);
    step(); chk("t2_pop", obs_pop, 4'b0010);
    step(); chk("t2_push", obs_push, 4'b0100); chk("t2_data", obs_dpush[2*16 +: 16], 16'h0202);
    step(); chk("t2_push_off", obs_push, 4'b0000);
    step();

    // Pointer now past driver 1: driver 0 must win before driver 1.
    load(0, 16'h0201); load(1, 16'h0301);
    step(); chk("fair_first", obs_pop, 4'b0001);
    repeat (3) step();
    step(); chk("fair_second", obs_pop, 4'b0010);
    repeat (3) step();

    // Broadcast from driver 3.
    load(3, 16'hFF55);
    step(); chk("bc_pop", obs_pop, 4'b1000);
    step(); chk("bc_push", obs_push, BC_EN ? 4'b0111 : 4'b0000);
    repeat (2) step();

    // Invalid destination is dropped; next packet serviced normally.
    load(0, 16'h0911); load(1, 16'h0311);
    step(); chk("inv_pop", obs_pop, 4'b0001);
    step(); chk("inv_push", obs_push, 4'b0000);
    repeat (2) step();
    step(); chk("inv_next_pop", obs_pop, 4'b0010);
    step(); chk("inv_next_push", obs_push, 4'b1000); chk("inv_next_data", obs_dpush[3*16 +: 16], 16'h0311);
    repeat (2) step();

    rand_on = 1'b1;
    repeat (400) step();
    rand_on = 1'b0;
    repeat (90) step();

    // Reset in the middle of a transfer.
    load(2, 16'h0233);
    step(); chk("mr_pop", obs_pop, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("mr_pop0", bif.pop, 0);
    chk("mr_push0", bif.push, 0);
    chk("mr_dpush0", bif.D_push, 0);
    model_reset();
    repeat (3) step();
    #3 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_push", obs_push, 4'b0000);
      chk("post_dpush", obs_dpush, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
